// File: rtl/tanh_lut_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one external tanh LUT.
// One lookup in flight: IDLE -> ISSUE -> CAPTURE -> RESP.
module tanh_lut_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            lut_addr,
  input  logic [DATA_W-1:0]            lut_data,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  input  logic                         rsp_ready,
  output logic                         busy,
  output logic [CNT_W-1:0]             lut_count
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e              r_state, w_state_next;
  logic [IdW-1:0]      r_rr_ptr, r_grant, r_rsp_id;
  logic [DATA_W-1:0]   r_lut_addr, r_rsp_data;
  logic [CNT_W-1:0]    r_lut_count;

  logic                w_found, w_accept, w_rsp_done;
  logic [IdW-1:0]      w_sel, w_idx, w_ptr_next;
  logic [DATA_W-1:0]   w_sel_addr;

  // First valid requester scanning upward from r_rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
      w_idx = (w_idx == IdW'(NUM_REQ - 1)) ? '0 : w_idx + IdW'(1);
    end
  end

  always_comb begin
    w_sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_sel == IdW'(k)) w_sel_addr = req_addr[k*DATA_W +: DATA_W];
    end
  end

  assign w_accept   = (r_state == StIdle) && w_found && !rst;
  assign w_rsp_done = (r_state == StResp) && rsp_ready;
  assign w_ptr_next = (r_grant == IdW'(NUM_REQ - 1)) ? '0 : r_grant + IdW'(1);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_accept) w_state_next = StIssue;
      StIssue:   w_state_next = StCapture;
      StCapture: w_state_next = StResp;
      StResp:    if (rsp_ready) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_rsp_id    <= '0;
      r_lut_addr  <= '0;
      r_rsp_data  <= '0;
      r_lut_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_lut_addr <= w_sel_addr;
        r_grant    <= w_sel;
      end
      // LUT output settled on the falling edge inside ISSUE; only sampled here.
      if (r_state == StCapture) begin
        r_rsp_data <= lut_data;
        r_rsp_id   <= r_grant;
      end
      if (w_rsp_done) begin
        r_rr_ptr <= w_ptr_next;
        if (r_lut_count != '1) r_lut_count <= r_lut_count + CNT_W'(1);
      end
    end
  end

  assign req_ready = w_accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign lut_addr  = r_lut_addr;
  assign rsp_valid = (r_state == StResp);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != StIdle);
  assign lut_count = r_lut_count;

endmodule

// File: tb/tb_tanh_lut_arbiter.sv
// Scoreboard bench for tanh_lut_arbiter: negedge LUT model plus a cycle-level
// reference model of arbitration, latency and response ordering.
module tb_tanh_lut_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   lut_addr;
  logic [DW-1:0]   lut_data;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_id;
  logic            rsp_ready = 1'b0;
  logic            busy;
  logic [CW-1:0]   lut_count;

  tanh_lut_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .lut_addr(lut_addr), .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy), .lut_count(lut_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Signed Q2.6 tanh, truncated toward zero.
  logic [7:0] tbl [256];

  always @(negedge clk) lut_data <= tbl[lut_addr];

  typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;
  exp_t         sb[$];
  int           ph = 0;     // 0 idle, 1..2 lookup in flight, 3 responding
  int           m_ptr = 0;
  int           m_id = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [N-1:0] acc_mask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] pick(input logic [N-1:0] v, input int ptr);
    logic [N-1:0] one;
    one = 1;
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return one << ((ptr + k) % N);
    end
    return '0;
  endfunction

  // Monitor + reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [N-1:0] er;
    exp_t e;
    er = '0;
    if (!rst && ph == 0) er = pick(req_valid, m_ptr);
    chk("req_ready", 32'(req_ready), 32'(er));
    acc_mask = req_valid & req_ready;
    if (!rst) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(ph == 3));
      chk("busy", 32'(busy), 32'(ph != 0));
      chk("lut_count", 32'(lut_count), 32'(m_cnt));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
          chk("sb_rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
    if (rst) begin
      ph = 0; m_ptr = 0; m_cnt = '0; sb.delete();
    end else begin
      case (ph)
        0: if (er != '0) begin
          for (int i = 0; i < N; i++) if (er[i]) m_id = i;
          sb.push_back(exp_t'({2'(m_id), tbl[req_addr[m_id*DW +: DW]]}));
          ph = 1;
        end
        1, 2: ph = ph + 1;
        default: if (rsp_ready) begin
          ph = 0;
          m_ptr = (m_id + 1) % N;
          if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
      endcase
    end
  end

  // Requesters drop valid once accepted.
  always @(posedge clk) begin
    #1;
    req_valid = req_valid & ~acc_mask;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[idx] && n < 20);
    chk("accept_seen", 32'(req_ready[idx]), 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    lat = n;
  endtask

  initial begin
    int lat;
    real x, e2;
    logic [7:0] a8;
    logic [7:0] ta [4];
    logic [7:0] td [4];
    for (int a = 0; a < 256; a++) begin
      a8 = 8'(a);
      x = real'($signed(a8)) / 64.0;
      e2 = $exp(2.0 * x);
      tbl[a] = 8'($rtoi((e2 - 1.0) / (e2 + 1.0) * 64.0));
    end
    ta[0] = 8'h10; ta[1] = 8'h20; ta[2] = 8'h80; ta[3] = 8'hFF;
    td[0] = 8'h0F; td[1] = 8'h1D; td[2] = 8'hC3; td[3] = 8'h00;

    // Single lookup: latency 3, count 1.
    do_reset();
    step();
    req_addr[1*DW +: DW] = 8'h40; req_valid = 4'b0010; rsp_ready = 1'b1;
    wait_ready(1);
    wait_rsp(lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_rsp_data", 32'(rsp_data), 32'h30);
    chk("t1_rsp_id", 32'(rsp_id), 32'd1);
    @(negedge clk);
    chk("t1_count", 32'(lut_count), 32'd1);

    // All four at once: round-robin order, 4-cycle spacing.
    do_reset();
    step();
    for (int i = 0; i < N; i++) req_addr[i*DW +: DW] = ta[i];
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      wait_rsp(lat);
      chk("t2_rsp_id", 32'(rsp_id), 32'(k));
      chk("t2_rsp_data", 32'(rsp_data), 32'(td[k]));
      if (k > 0) chk("t2_spacing", 32'(lat), 32'd4);
    end

    // After serving 2, pointer is 3: grant 3 before 0.
    do_reset();
    step();
    req_addr[2*DW +: DW] = 8'h33; req_valid = 4'b0100; rsp_ready = 1'b1;
    wait_rsp(lat);
    step();
    req_addr[0 +: DW] = 8'h05; req_addr[3*DW +: DW] = 8'hA0; req_valid = 4'b1001;
    wait_ready(3);
    chk("t3_first", 32'(req_ready), 32'b1000);
    wait_ready(0);
    chk("t3_second", 32'(req_ready), 32'b0001);

    // Back-pressure in RESP.
    do_reset();
    step();
    req_addr[0 +: DW] = 8'h55; req_valid = 4'b0001; rsp_ready = 1'b0;
    wait_rsp(lat);
    step();
    req_addr[2*DW +: DW] = 8'h77; req_valid = req_valid | 4'b0100;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_data", 32'(rsp_data), 32'(tbl[8'h55]));
      chk("t4_hold_id", 32'(rsp_id), 32'd0);
      chk("t4_ready_low", 32'(req_ready), 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_handshake", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("t4_next_accept", 32'(req_ready), 32'b0100);

    // Reset during CAPTURE abandons the lookup and clears rr_ptr.
    do_reset();
    step();
    req_addr[2*DW +: DW] = 8'h12; req_valid = 4'b0100; rsp_ready = 1'b1;
    wait_rsp(lat);
    step();
    req_addr[1*DW +: DW] = 8'h44; req_valid = 4'b0010;
    wait_ready(1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; req_valid = 4'b1010;
    @(negedge clk);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_count", 32'(lut_count), 32'd0);
    chk("t5_rr_ptr", 32'(req_ready), 32'b0010);
    wait_rsp(lat);

    // Saturating counter.
    do_reset();
    step();
    force dut.r_lut_count = '1;
    m_cnt = '1;
    #1;
    release dut.r_lut_count;
    req_addr[0 +: DW] = 8'h01; req_valid = 4'b0001; rsp_ready = 1'b1;
    wait_rsp(lat);
    @(negedge clk);
    chk("t6_saturate", 32'(lut_count), 32'(16'hFFFF));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      step();
      rst = ($urandom % 250 == 0);
      rsp_ready = ($urandom % 4 != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom % 4 == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*DW +: DW] = 8'($urandom);
        end else if (req_valid[i] && $urandom % 20 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    step();
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    repeat (10) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
